// File: rtl/wb_regfile.sv
// Writeback stage and 32-entry architectural register file.
// Selects ALU/memory data, commits it, and serves two bypassed read ports to ID.
module wb_regfile #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned CNT_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  startin,
  input  logic                  WB_reg_write,
  input  logic                  WB_mem_to_reg,
  input  logic [DATA_WIDTH-1:0] WB_mem_data,
  input  logic [DATA_WIDTH-1:0] WB_alu_result,
  input  logic [4:0]            WB_reg_dst_mux_out,
  input  logic [4:0]            ID_rs,
  input  logic [4:0]            ID_rt,
  output logic [DATA_WIDTH-1:0] ID_read_data1,
  output logic [DATA_WIDTH-1:0] ID_read_data2,
  output logic [DATA_WIDTH-1:0] WB_write_data,
  output logic [CNT_WIDTH-1:0]  wb_commit_count
);

  localparam int unsigned NREGS = 32;

  logic [DATA_WIDTH-1:0] regs_q [NREGS];
  logic [CNT_WIDTH-1:0]  count_q;
  logic [CNT_WIDTH-1:0]  count_d;
  logic                  commit_c;

  assign WB_write_data = WB_mem_to_reg ? WB_mem_data : WB_alu_result;

  // Writes to r0 and writes colliding with reset are dropped and not counted.
  assign commit_c = WB_reg_write && (WB_reg_dst_mux_out != 5'd0) && !startin;

  always_comb begin
    count_d = count_q;
    if (commit_c) begin
      count_d = count_q + CNT_WIDTH'(1);
    end
  end

  // Read port 1: r0 reads zero, then same-cycle bypass, then array.
  always_comb begin
    ID_read_data1 = regs_q[ID_rs];
    if (ID_rs == 5'd0) begin
      ID_read_data1 = '0;
    end else if (commit_c && (ID_rs == WB_reg_dst_mux_out)) begin
      ID_read_data1 = WB_write_data;
    end
  end

  always_comb begin
    ID_read_data2 = regs_q[ID_rt];
    if (ID_rt == 5'd0) begin
      ID_read_data2 = '0;
    end else if (commit_c && (ID_rt == WB_reg_dst_mux_out)) begin
      ID_read_data2 = WB_write_data;
    end
  end

  always_ff @(posedge clk) begin
    if (startin) begin
      for (int unsigned i = 0; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
      count_q <= '0;
    end else begin
      if (commit_c) begin
        regs_q[WB_reg_dst_mux_out] <= WB_write_data;
      end
      count_q <= count_d;
    end
  end

  assign wb_commit_count = count_q;

endmodule

// File: tb/tb_wb_regfile.sv
// Bench for wb_regfile: directed literal checks plus randomized traffic
// compared every cycle against an array-based reference model.
module tb_wb_regfile;

  logic        clk;
  logic        startin;
  logic        we;
  logic        m2r;
  logic [31:0] mdata;
  logic [31:0] alu;
  logic [4:0]  dst;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [31:0] rd1, rd2, wdata, cnt;
  logic [31:0] rd1_s, rd2_s, wdata_s;
  logic [3:0]  cnt4;

  int passed = 0;
  int total  = 0;

  logic [31:0] m_regs [32];
  int unsigned m_cnt = 0;
  bit          reset_done = 0;

  wb_regfile dut (
    .clk(clk), .startin(startin), .WB_reg_write(we), .WB_mem_to_reg(m2r),
    .WB_mem_data(mdata), .WB_alu_result(alu), .WB_reg_dst_mux_out(dst),
    .ID_rs(rs), .ID_rt(rt), .ID_read_data1(rd1), .ID_read_data2(rd2),
    .WB_write_data(wdata), .wb_commit_count(cnt)
  );

  // Narrow-counter instance shares the stimulus to exercise counter wrap.
  wb_regfile #(.DATA_WIDTH(32), .CNT_WIDTH(4)) dut4 (
    .clk(clk), .startin(startin), .WB_reg_write(we), .WB_mem_to_reg(m2r),
    .WB_mem_data(mdata), .WB_alu_result(alu), .WB_reg_dst_mux_out(dst),
    .ID_rs(rs), .ID_rt(rt), .ID_read_data1(rd1_s), .ID_read_data2(rd2_s),
    .WB_write_data(wdata_s), .wb_commit_count(cnt4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end else begin
      passed++;
    end
  endtask

  function automatic logic [31:0] exp_read(input logic [4:0] idx);
    logic [31:0] sel;
    sel = m2r ? mdata : alu;
    if (idx == 5'd0) return 32'd0;
    if (!startin && we && dst != 5'd0 && idx == dst) return sel;
    return m_regs[idx];
  endfunction

  // Compare outputs mid-cycle, then advance the model by the edge to come.
  always @(negedge clk) begin
    if (reset_done) begin
      chk("wdata", wdata, m2r ? mdata : alu);
      chk("rd1", rd1, exp_read(rs));
      chk("rd2", rd2, exp_read(rt));
      chk("rd1_w4", rd1_s, exp_read(rs));
      chk("count", cnt, m_cnt);
      chk("count4", {28'd0, cnt4}, {28'd0, 4'(m_cnt)});
    end
    if (startin) begin
      for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
      m_cnt = 0;
      reset_done = 1'b1;
    end else if (we && dst != 5'd0) begin
      m_regs[dst] = m2r ? mdata : alu;
      m_cnt++;
    end
  end

  task automatic drive(input logic s, input logic w, input logic m,
                       input logic [31:0] md, input logic [31:0] a,
                       input logic [4:0] d, input logic [4:0] r1, input logic [4:0] r2);
    startin = s; we = w; m2r = m; mdata = md; alu = a; dst = d; rs = r1; rt = r2;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    drive(1, 0, 0, 32'd0, 32'd0, 5'd0, 5'd0, 5'd0);
    next_cycle();
    next_cycle();

    drive(0, 0, 0, 32'd0, 32'd0, 5'd0, 5'd5, 5'd31);
    #1;
    chk("lit_reset_rs5", rd1, 32'd0);
    chk("lit_reset_rt31", rd2, 32'd0);
    chk("lit_reset_cnt", cnt, 32'd0);

    next_cycle();
    drive(0, 1, 0, 32'd0, 32'hAABBCCDD, 5'd25, 5'd25, 5'd0);
    next_cycle();
    drive(0, 0, 0, 32'd0, 32'd0, 5'd0, 5'd25, 5'd0);
    #1;
    chk("lit_alu_r25", rd1, 32'hAABBCCDD);
    chk("lit_alu_cnt", cnt, 32'd1);

    next_cycle();
    drive(0, 1, 1, 32'h11111111, 32'hBBCCDDEE, 5'd21, 5'd21, 5'd21);
    #1;
    chk("lit_byp_rd1", rd1, 32'h11111111);
    chk("lit_byp_rd2", rd2, 32'h11111111);
    chk("lit_byp_wdata", wdata, 32'h11111111);
    next_cycle();
    drive(0, 0, 0, 32'd0, 32'd0, 5'd0, 5'd21, 5'd21);
    #1;
    chk("lit_mem_r21", rd1, 32'h11111111);
    chk("lit_mem_cnt", cnt, 32'd2);

    next_cycle();
    drive(0, 1, 0, 32'd0, 32'hCCDDEEFF, 5'd0, 5'd0, 5'd0);
    #1;
    chk("lit_r0_rd", rd1, 32'd0);
    chk("lit_r0_wdata", wdata, 32'hCCDDEEFF);
    next_cycle();
    drive(0, 0, 1, 32'h33333333, 32'd0, 5'd13, 5'd13, 5'd0);
    #1;
    chk("lit_r0_cnt", cnt, 32'd2);
    chk("lit_nowe_byp", rd1, 32'd0);
    next_cycle();
    drive(0, 0, 0, 32'd0, 32'd0, 5'd0, 5'd13, 5'd0);
    #1;
    chk("lit_nowe_r13", rd1, 32'd0);
    chk("lit_nowe_cnt", cnt, 32'd2);

    next_cycle();
    drive(1, 1, 0, 32'd0, 32'hDEADBEEF, 5'd7, 5'd7, 5'd25);
    #1;
    chk("lit_rst_nobyp", rd1, 32'd0);
    chk("lit_rst_old25", rd2, 32'hAABBCCDD);
    next_cycle();
    drive(0, 0, 0, 32'd0, 32'd0, 5'd0, 5'd7, 5'd25);
    #1;
    chk("lit_rst_r7", rd1, 32'd0);
    chk("lit_rst_r25", rd2, 32'd0);
    chk("lit_rst_cnt", cnt, 32'd0);

    for (int i = 0; i < 17; i++) begin
      next_cycle();
      drive(0, 1, 0, 32'd0, 32'(i), 5'd1, 5'd0, 5'd0);
    end
    next_cycle();
    drive(0, 0, 0, 32'd0, 32'd0, 5'd0, 5'd1, 5'd0);
    #1;
    chk("lit_wrap_cnt4", {28'd0, cnt4}, 32'd1);
    chk("lit_wrap_cnt", cnt, 32'd17);
    chk("lit_wrap_r1", rd1, 32'd16);

    for (int i = 0; i < 3000; i++) begin
      logic [4:0] d;
      next_cycle();
      d = ($urandom_range(7) == 0) ? 5'd0 : 5'($urandom_range(31));
      drive(($urandom_range(63) == 0), ($urandom_range(1) == 1), ($urandom_range(1) == 1),
            $urandom, $urandom, d,
            ($urandom_range(2) == 0) ? d : 5'($urandom_range(31)),
            ($urandom_range(2) == 0) ? d : 5'($urandom_range(31)));
    end

    next_cycle();
    drive(0, 0, 0, 32'd0, 32'd0, 5'd0, 5'd0, 5'd0);
    next_cycle();
    next_cycle();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/wb_regfile.md
Name: wb_regfile

Overview:
- Consumer end of the MEM/WB pipeline interface: the writeback stage plus the architectural register file it writes.
- Takes the WB_* outputs of the MEM/WB register and selects write data (memory vs ALU).
- Commits the selected data to a 32-entry register file and serves two read ports to the ID stage with same-cycle write bypass.
- Also exports the selected writeback data for forwarding, and keeps a committed-write counter.

Parameters:
- DATA_WIDTH, 32, width of each register and of the data paths
- CNT_WIDTH, 32, width of the committed-write counter

Ports:
- clk  input  1  system clock; all state updates on rising edge
- startin  input  1  reset; synchronous, active-high
- WB_reg_write  input  1  register write enable from MEM/WB
- WB_mem_to_reg  input  1  1 = write memory data, 0 = write ALU result
- WB_mem_data  input  DATA_WIDTH  load data from MEM/WB
- WB_alu_result  input  DATA_WIDTH  ALU result from MEM/WB
- WB_reg_dst_mux_out  input  5  destination register index
- ID_rs  input  5  read port 1 index
- ID_rt  input  5  read port 2 index
- ID_read_data1  output  DATA_WIDTH  contents of register ID_rs
- ID_read_data2  output  DATA_WIDTH  contents of register ID_rt
- WB_write_data  output  DATA_WIDTH  selected writeback data (forwarding source)
- wb_commit_count  output  CNT_WIDTH  number of committed register writes

Behaviour:
- Write-data mux is combinational: WB_write_data = WB_mem_to_reg ? WB_mem_data : WB_alu_result.
  - Valid whenever the inputs are valid, independent of WB_reg_write.
- Commit condition: WB_reg_write=1, WB_reg_dst_mux_out != 0 and startin=0.
  - On the rising edge, regs[WB_reg_dst_mux_out] <= WB_write_data.
- Register 0 is hardwired to zero: writes to index 0 are discarded, and reads of index 0 always return 0.
- Read ports are combinational.
  - ID_read_dataN = 0 if index is 0.
  - Otherwise, if the commit condition holds this cycle and index == WB_reg_dst_mux_out, return WB_write_data (write-before-read bypass, zero-cycle).
  - Otherwise return regs[index].
  - Both ports bypass independently; rs == rt is legal and both return the same value.
- Reset, sampled on a rising edge with startin=1:
  - all 32 registers <= 0 and wb_commit_count <= 0.
  - The commit is suppressed in that cycle even if WB_reg_write=1.
  - Bypass is disabled while startin=1, so reads return current array contents.
- Reset mid-operation: a write presented in the same cycle as startin is lost. The first write after startin deasserts proceeds normally.
- Counter: wb_commit_count increments by 1 on every edge where the commit condition holds.
  - Writes to index 0 are not counted.
  - It wraps modulo 2^CNT_WIDTH with no saturation.
- Latency: a committed value is visible through the array from the cycle after the edge, and in the same cycle via bypass.
- No X propagation: every output is defined after the first reset edge. Before the first reset, register contents are undefined.

Test Plan:
- Reset clear: startin=1 for one edge, then read rs=5, rt=31 -> both 0; wb_commit_count=0.
- ALU write: reg_write=1, mem_to_reg=0, alu_result=AABBCCDD, dst=25, edge; then rs=25 -> ID_read_data1=AABBCCDD; count=1.
- Memory write with bypass: reg_write=1, mem_to_reg=1, mem_data=11111111, alu_result=BBCCDDEE, dst=21, and rs=rt=21 in the same cycle.
  - Before the edge, both reads = 11111111 and WB_write_data = 11111111.
  - After the edge, the array holds 11111111; count=2.
- Register zero: reg_write=1, dst=0, alu_result=CCDDEEFF, edge; rs=0 -> 0; count unchanged; WB_write_data = CCDDEEFF.
- reg_write=0: mem_to_reg=1, mem_data=33333333, dst=13, edge; rs=13 -> prior value (0); no bypass; count unchanged.
- Reset collision and wrap:
  - With startin=1 and reg_write=1, dst=7, data=DEADBEEF, edge -> r7=0, count=0.
  - With CNT_WIDTH=4, 17 commits to dst=1 -> count=1.
